gb_fb_write_sched: RTL and testbench

Write-side controller for the GameBoy LCD framebuffer. Accepts the 2-bit pixel stream from the PPU pixel conduit, sequences it into a 160x144 frame with raster-order addressing, and manages ping-pong bank ownership between the PPU writer and the VGA reader. Banks swap only at frame boundaries while the display is in vertical blank, so the VGA side never scans a half-written frame. Sits between the PPU pixel conduit and the write port of the dual-port framebuffer RAM, in the GameBoy clock domain.

---
 rtl/gb_fb_write_sched.sv | 156 +++++++++++++++
 tb/tb_gb_fb_write_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_fb_write_sched.sv
// Write-side framebuffer sequencer: PPU pixel stream to raster addresses, with bank ownership control.
// Optional FB_DOUBLE_BUFFER_EN enables ping-pong banks swapped in display vblank; default is single bank.
module gb_fb_write_sched #(
    parameter int unsigned GB_W = 160,
    parameter int unsigned GB_H = 144,
    parameter int unsigned AW   = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    LD,
    input  logic          PX_VALID,
    input  logic          FRAME_START,
    input  logic          disp_vblank,
    input  logic          err_clr,
    output logic          fb_we,
    output logic [AW:0]   fb_waddr,
    output logic [1:0]    fb_wdata,
    output logic          rd_bank,
    output logic          swap,
    output logic          frame_done,
    output logic          err_overflow,
    output logic          err_short,
    output logic [7:0]    dropped
);

    typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

    localparam logic [AW-1:0] LastAddr = AW'(GB_W * GB_H - 1);
    localparam logic [7:0]    XLast    = 8'(GB_W - 1);

    state_e        r_state;
    logic [AW-1:0] r_pix_addr;
    logic [7:0]    r_x;
    logic [7:0]    r_y;
    logic          r_rd_bank;

    logic w_swap_now;
    logic w_drop_frame;
    logic w_done_exit;
    logic w_wr_bank;
    logic w_start_bank;
    logic w_ovf_set;
    logic w_short_set;

`ifdef FB_DOUBLE_BUFFER_EN
    localparam logic RdBankRst = 1'b1;

    assign w_swap_now   = (r_state == StDone) && disp_vblank;
    assign w_drop_frame = (r_state == StDone) && FRAME_START && !disp_vblank;
    assign w_done_exit  = disp_vblank;
    assign w_wr_bank    = ~r_rd_bank;
`else
    localparam logic RdBankRst = 1'b0;

    logic w_unused_vblank;
    assign w_unused_vblank = disp_vblank;

    assign w_swap_now   = 1'b0;
    assign w_drop_frame = 1'b0;
    assign w_done_exit  = 1'b1;
    assign w_wr_bank    = 1'b0;
`endif

    // A swap in the same cycle as a new frame hands the old read bank to the writer.
    assign w_start_bank = w_swap_now ? r_rd_bank : w_wr_bank;
    assign w_ovf_set    = PX_VALID && !FRAME_START && (r_state != StWrite);
    assign w_short_set  = FRAME_START && (r_state == StWrite);
    assign rd_bank      = r_rd_bank;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_pix_addr   <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_rd_bank    <= RdBankRst;
            fb_we        <= 1'b0;
            fb_waddr     <= '0;
            fb_wdata     <= '0;
            swap         <= 1'b0;
            frame_done   <= 1'b0;
            err_overflow <= 1'b0;
            err_short    <= 1'b0;
            dropped      <= '0;
        end else begin
            fb_we        <= 1'b0;
            frame_done   <= 1'b0;
            swap         <= w_swap_now;
            err_overflow <= w_ovf_set | (err_overflow & ~err_clr);
            err_short    <= w_short_set | (err_short & ~err_clr);

            if (w_swap_now) begin
                r_rd_bank <= ~r_rd_bank;
            end
            if (w_drop_frame && (dropped != 8'hFF)) begin
                dropped <= dropped + 8'd1;
            end

            if (FRAME_START) begin
                r_state    <= StWrite;
                r_pix_addr <= '0;
                r_x        <= '0;
                r_y        <= '0;
                if (PX_VALID) begin
                    fb_we      <= 1'b1;
                    fb_waddr   <= {w_start_bank, {AW{1'b0}}};
                    fb_wdata   <= LD;
                    r_pix_addr <= AW'(1);
                    r_x        <= 8'd1;
                end
            end else begin
                unique case (r_state)
                    StIdle: begin
                        r_state <= StIdle;
                    end
                    StWrite: begin
                        if (PX_VALID) begin
                            fb_we      <= 1'b1;
                            fb_waddr   <= {w_wr_bank, r_pix_addr};
                            fb_wdata   <= LD;
                            r_pix_addr <= r_pix_addr + AW'(1);
                            if (r_x == XLast) begin
                                r_x <= '0;
                                r_y <= r_y + 8'd1;
                            end else begin
                                r_x <= r_x + 8'd1;
                            end
                            if (r_pix_addr == LastAddr) begin
                                frame_done <= 1'b1;
                                r_state    <= StDone;
                            end
                        end
                    end
                    StDone: begin
                        if (w_done_exit) begin
                            r_state <= StIdle;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

`ifndef SYNTHESIS
    // x/y exist only to cross-check the incremental address against raster position.
    always @(posedge clk) begin
        if (!reset && (r_state == StWrite)) begin
            assert (32'(r_pix_addr) == 32'(r_y) * GB_W + 32'(r_x));
        end
    end
`endif

endmodule

// File: tb/tb_gb_fb_write_sched.sv
// Scoreboard bench for gb_fb_write_sched: a frame-level model predicts writes, swaps and flags.
// Follows FB_DOUBLE_BUFFER_EN the same way as the design.
module tb_gb_fb_write_sched;

    localparam int GB_W = 160;
    localparam int GB_H = 144;
    localparam int AW   = 15;
    localparam int NPIX = GB_W * GB_H;
`ifdef FB_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif
    localparam int MIdle  = 0;
    localparam int MWrite = 1;
    localparam int MDone  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    LD = '0;
    logic          PX_VALID = 1'b0;
    logic          FRAME_START = 1'b0;
    logic          disp_vblank = 1'b0;
    logic          err_clr = 1'b0;
    logic          fb_we;
    logic [AW:0]   fb_waddr;
    logic [1:0]    fb_wdata;
    logic          rd_bank;
    logic          swap;
    logic          frame_done;
    logic          err_overflow;
    logic          err_short;
    logic [7:0]    dropped;

    always #5 clk = ~clk;

    gb_fb_write_sched #(.GB_W(GB_W), .GB_H(GB_H), .AW(AW)) dut (
        .clk(clk), .reset(reset), .LD(LD), .PX_VALID(PX_VALID), .FRAME_START(FRAME_START),
        .disp_vblank(disp_vblank), .err_clr(err_clr), .fb_we(fb_we), .fb_waddr(fb_waddr),
        .fb_wdata(fb_wdata), .rd_bank(rd_bank), .swap(swap), .frame_done(frame_done),
        .err_overflow(err_overflow), .err_short(err_short), .dropped(dropped)
    );

    typedef struct packed {
        logic [AW:0] addr;
        logic [1:0]  data;
        logic        done;
    } wexp_t;

    wexp_t       wq[$];
    bit          sq[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [1:0]  dut_mem   [0:2**(AW+1)-1];
    logic [1:0]  model_mem [0:2**(AW+1)-1];
    logic [AW:0] last_waddr = '0;
    logic [AW:0] last_done_addr = '0;
    int          swaps_seen = 0;

    // Frame-level reference state
    int m_mode = MIdle;
    int m_pix = 0;
    bit m_rd = DB;
    bit m_ovf = 0;
    bit m_short = 0;
    int m_dropped = 0;
    int m_swaps = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic emit(input logic [1:0] ld);
        wexp_t e;
        logic  wb;
        wb     = DB ? ~m_rd : 1'b0;
        e.addr = {wb, AW'(m_pix)};
        e.data = ld;
        e.done = (m_pix == NPIX - 1);
        wq.push_back(e);
        model_mem[e.addr] = ld;
        if (e.done) m_mode = MDone;
        m_pix++;
    endtask

    task automatic model_step(input bit fs, input bit pv, input logic [1:0] ld, input bit vb,
                              input bit clr);
        int mode0;
        bit ovf_s;
        bit short_s;
        mode0   = m_mode;
        ovf_s   = 0;
        short_s = 0;
        if (DB && mode0 == MDone && vb) begin
            m_rd = ~m_rd;
            m_swaps++;
            sq.push_back(m_rd);
        end
        if (DB && mode0 == MDone && fs && !vb && m_dropped < 255) m_dropped++;
        if (fs) begin
            short_s = (mode0 == MWrite);
            m_mode  = MWrite;
            m_pix   = 0;
            if (pv) emit(ld);
        end else begin
            if (pv && mode0 == MWrite) emit(ld);
            else if (pv) ovf_s = 1;
            if (mode0 == MDone && (!DB || vb)) m_mode = MIdle;
        end
        m_ovf   = ovf_s || (m_ovf && !clr);
        m_short = short_s || (m_short && !clr);
    endtask

    task automatic cycle(input bit fs, input bit pv, input logic [1:0] ld, input bit vb,
                         input bit clr);
        FRAME_START = fs;
        PX_VALID    = pv;
        LD          = ld;
        disp_vblank = vb;
        err_clr     = clr;
        model_step(fs, pv, ld, vb, clr);
        @(posedge clk);
        #2;
    endtask

    task automatic run_pixels(input int n, input bit gaps, input bit ld_addr);
        int done_n;
        bit vb;
        done_n = 0;
        while (done_n < n) begin
            vb = ($urandom_range(0, 3) == 0);
            if (gaps && $urandom_range(0, 15) == 0) begin
                cycle(1'b0, 1'b0, 2'd0, vb, 1'b0);
            end else begin
                cycle(1'b0, 1'b1, ld_addr ? 2'(m_pix) : 2'($urandom), vb, 1'b0);
                done_n++;
            end
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_err_overflow"}, err_overflow, m_ovf);
        chk({tag, "_err_short"}, err_short, m_short);
        chk({tag, "_dropped"}, dropped, m_dropped);
        chk({tag, "_rd_bank"}, rd_bank, m_rd);
        chk({tag, "_swap_count"}, swaps_seen, m_swaps);
        chk({tag, "_pending"}, wq.size() + sq.size(), 0);
    endtask

    task automatic chk_mem(input string name);
        int bad;
        bad = 0;
        for (int a = 0; a < 2**(AW+1); a++) begin
            if (dut_mem[a] !== model_mem[a]) bad++;
        end
        chk(name, bad, 0);
    endtask

    task automatic do_reset(input string tag);
        reset       = 1'b1;
        FRAME_START = 1'b0;
        PX_VALID    = 1'b0;
        LD          = '0;
        disp_vblank = 1'b0;
        err_clr     = 1'b0;
        m_mode      = MIdle;
        m_pix       = 0;
        m_rd        = DB;
        m_ovf       = 0;
        m_short     = 0;
        m_dropped   = 0;
        wq.delete();
        sq.delete();
        #1;
        chk({tag, "_fb_we"}, fb_we, 0);
        chk({tag, "_fb_waddr"}, fb_waddr, 0);
        chk({tag, "_fb_wdata"}, fb_wdata, 0);
        chk({tag, "_swap"}, swap, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_err_overflow"}, err_overflow, 0);
        chk({tag, "_err_short"}, err_short, 0);
        chk({tag, "_dropped"}, dropped, 0);
        chk({tag, "_rd_bank"}, rd_bank, DB ? 1 : 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Monitor: consumes expected writes/swaps whenever the DUT presents one.
    always begin
        @(posedge clk);
        #1;
        if (fb_we || frame_done) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", {fb_we, frame_done}, 0);
            end else begin
                wexp_t e;
                e = wq.pop_front();
                chk("write", {fb_we, fb_waddr, fb_wdata, frame_done},
                    {1'b1, e.addr, e.data, e.done});
            end
            if (fb_we) begin
                dut_mem[fb_waddr] = fb_wdata;
                last_waddr = fb_waddr;
                if (frame_done) last_done_addr = fb_waddr;
            end
        end
        if (swap) begin
            swaps_seen++;
            if (sq.size() == 0) chk("unexpected_swap", swap, 0);
            else chk("swap_rd_bank", rd_bank, sq.pop_front());
        end
    end

    initial begin
        for (int a = 0; a < 2**(AW+1); a++) begin
            dut_mem[a]   = 2'd0;
            model_mem[a] = 2'd0;
        end
        #3;
        do_reset("rst");

        // Frame A: contiguous pixels, LD = addr[1:0]
        cycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        run_pixels(NPIX, 1'b0, 1'b1);
        chk("frameA_last_addr", last_done_addr, 16'h59FF);
        chk_state("frameA");
        chk_mem("frameA_mem");

        // Hold off vblank, then release it
        for (int i = 0; i < 100; i++) cycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        chk_state("vblank_low");
        cycle(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        chk_state("vblank_high");
        chk("swapped_rd_bank", rd_bank, 0);

        // Pixels with no frame open
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 2'($urandom), 1'b0, 1'b0);
        chk_state("idle_px");
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        chk_state("idle_clr");

        // Frame B: short frame after 5000 pixels
        cycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        run_pixels(1, 1'b0, 1'b0);
        chk("frameB_bank", last_waddr[AW], DB ? 1 : 0);
        run_pixels(4999, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 2'($urandom), 1'b0, 1'b0);
        chk_state("short");
        chk("short_restart_addr", last_waddr[AW-1:0], 0);
        cycle(1'b0, 1'b1, 2'($urandom), 1'b0, 1'b1);
        chk_state("short_clr");
        run_pixels(NPIX - 2, 1'b0, 1'b0);
        chk_state("frameB_done");

        // Pixel while done, then a frame start with vblank low
        cycle(1'b0, 1'b1, 2'($urandom), 1'b0, 1'b0);
        chk_state("done_px");
        cycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        chk_state("drop");
        chk("drop_count", dropped, DB ? 1 : 0);

        // Frame C, then frame start coincident with vblank and pixel 0
        run_pixels(NPIX, 1'b0, 1'b0);
        chk_state("frameC_done");
        cycle(1'b1, 1'b1, 2'($urandom), 1'b1, 1'b0);
        chk_state("swap_start");
        chk("swap_start_addr", last_waddr, {(DB ? ~m_rd : 1'b0), 15'd0});
        run_pixels(999, 1'b0, 1'b0);
        chk_state("pre_reset");

        do_reset("mid_rst");
        cycle(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        run_pixels(300, 1'b1, 1'b0);
        chk_state("clean");
        chk("clean_last_addr", last_waddr, 16'd299);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 399) == 0, $urandom_range(0, 4) != 0, 2'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        chk_state("random");
        chk_mem("final_mem");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
